// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide, one bit per cycle.
// Shift-add multiply and restoring divide share one {hi,lo} register pair.
// Optional macro MULDIV_SIGNED_EN adds two's-complement handling on i_sgn.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,     // asynchronous, active low
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [1:0]       i_op,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_zero
);
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b, r_a;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_div_zero;

  logic               w_accept, w_last, w_dz, w_finish;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_it_hi, w_it_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_res;

  assign w_accept = (r_state != S_RUN) && i_start && !i_flush;
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));
  // divide by zero short-circuits after the first RUN cycle
  assign w_dz     = r_op[1] && (r_b == '0);
  assign w_finish = (r_state == S_RUN) && (w_last || w_dz);

  // one multiply step: add multiplicand on lsb, shift product right
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // one restoring divide step: shift in next dividend bit, trial subtract
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_it_hi = r_op[1] ? (w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0])
                           : w_sum[WIDTH:1];
  assign w_it_lo = r_op[1] ? {r_lo[WIDTH-2:0], w_ge}
                           : {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_prod  = {w_it_hi, w_it_lo};

`ifdef MULDIV_SIGNED_EN
  logic r_neg_q, r_neg_r;

  // signed ops run the unsigned core on magnitudes
  assign w_mag_a = (i_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b = (i_sgn && i_b[WIDTH-1]) ? -i_b : i_b;

  // remember result signs: product/quotient by xor, remainder follows dividend
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= i_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r <= i_sgn && i_a[WIDTH-1];
    end
  end

  assign w_prod_s = r_neg_q ? -w_prod  : w_prod;
  assign w_quo_s  = r_neg_q ? -w_it_lo : w_it_lo;
  assign w_rem_s  = r_neg_r ? -w_it_hi : w_it_hi;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = i_sgn;
  assign w_mag_a  = i_a;
  assign w_mag_b  = i_b;
  assign w_prod_s = w_prod;
  assign w_quo_s  = w_it_lo;
  assign w_rem_s  = w_it_hi;
`endif

  // final result select, evaluated on the edge that enters DONE
  always_comb begin
    w_res = '0;
    if (w_dz) begin
      w_res = r_op[0] ? r_a : '1;
    end else begin
      case (r_op)
        2'b00:   w_res = w_prod_s[WIDTH-1:0];
        2'b01:   w_res = w_prod_s[2*WIDTH-1:WIDTH];
        2'b10:   w_res = w_quo_s;
        default: w_res = w_rem_s;
      endcase
    end
  end

  // state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state logic; flush overrides everything including start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_finish) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  // operand capture, per-cycle iteration and result register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_a        <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= w_mag_a;
      r_b   <= w_mag_b;
      r_a   <= i_a;
      r_op  <= i_op;
    end else if (r_state == S_RUN && !i_flush) begin
      r_hi  <= w_it_hi;
      r_lo  <= w_it_lo;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_finish) begin
        r_result   <= w_res;
        r_div_zero <= w_dz;
      end
    end
  end

  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);
  assign o_result   = r_result;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=16): driver pushes expected
// responses from an arithmetic reference model, a monitor pops on done.
module tb_muldiv_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, flush = 1'b0, sgn = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] result;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_flush(flush),
    .i_op(op), .i_sgn(sgn), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_result(result), .o_div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: plain integer arithmetic
  function automatic void model(input logic [1:0] mop, input logic msg,
                                input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] res, output logic dz);
    logic [31:0] p, qv, rv;
    int sa, sb, q, r;
    bit s;
    s = 1'b0;
`ifdef MULDIV_SIGNED_EN
    s = msg;
`endif
    dz = 1'b0;
    if (mop[1] && mb == 0) begin
      dz  = 1'b1;
      res = mop[0] ? ma : {W{1'b1}};
    end else if (!s) begin
      p = {16'b0, ma} * {16'b0, mb};
      case (mop)
        2'b00:   res = p[15:0];
        2'b01:   res = p[31:16];
        2'b10:   res = ma / mb;
        default: res = ma % mb;
      endcase
    end else begin
      sa = $signed(ma);
      sb = $signed(mb);
      p  = sa * sb;
      if (mop[1]) begin
        q = sa / sb; r = sa % sb;
        qv = q; rv = r;
      end else begin
        qv = '0; rv = '0;
      end
      case (mop)
        2'b00:   res = p[15:0];
        2'b01:   res = p[31:16];
        2'b10:   res = qv[15:0];
        default: res = rv[15:0];
      endcase
    end
  endfunction

  // drive one start pulse; optionally record its expected response
  task automatic issue(logic [1:0] iop, logic isg, logic [W-1:0] ia,
                       logic [W-1:0] ib, bit push);
    exp_t e;
    op = iop; sgn = isg; a = ia; b = ib; start = 1'b1;
    if (push) begin
      model(iop, isg, ia, ib, e.res, e.dz);
      e.cyc = cyc + ((iop[1] && ib == 0) ? 2 : W + 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1 start = 1'b0;
  endtask

  // wait (bounded) for done; returns at the negedge of the done cycle
  task automatic wait_done(output int nbusy);
    bit got;
    got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (busy) nbusy++;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run(logic [1:0] iop, logic isg, logic [W-1:0] ia, logic [W-1:0] ib);
    int nb;
    issue(iop, isg, ia, ib, 1'b1);
    wait_done(nb);
    @(posedge clk); #1;
  endtask

  // monitor: every done pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL spurious_done: done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("div_zero", div_zero, e.dz);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int nb, c0, ndone;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_dz", div_zero, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // multiply with busy-length check
    issue(2'b00, 1'b0, 16'd300, 16'd200, 1'b1);
    wait_done(nb);
    chk("busy_cycles", nb, W);
    @(posedge clk); #1;
    run(2'b01, 1'b0, 16'd300, 16'd200);
    run(2'b01, 1'b0, 16'hFFFF, 16'hFFFF);
    run(2'b00, 1'b0, 16'hFFFF, 16'hFFFF);

    // divide, then back-to-back start in the done cycle
    issue(2'b10, 1'b0, 16'd1000, 16'd7, 1'b1);
    wait_done(nb);
    issue(2'b10, 1'b0, 16'd9, 16'd3, 1'b1);
    wait_done(nb);
    @(posedge clk); #1;
    run(2'b11, 1'b0, 16'd1000, 16'd7);

    // divide by zero
    run(2'b10, 1'b0, 16'h1234, 16'h0000);
    run(2'b11, 1'b0, 16'h1234, 16'h0000);

    // flush in cycle 5: no done, result/div_zero held
    issue(2'b10, 1'b0, 16'd50, 16'd5, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done) ndone++; end
    chk("flush_no_done", ndone, 0);
    chk("flush_result_held", result, 16'h1234);
    chk("flush_dz_held", div_zero, 1);

    // flush and start together: start dropped
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 16'd3; b = 16'd3;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", busy, 0);
    @(posedge clk); #1;

    // starts while busy are ignored
    issue(2'b10, 1'b0, 16'd1000, 16'd7, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b11; a = 16'd9; b = 16'd3;
    repeat (6) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(nb);
    @(posedge clk); #1;

    // reset mid-operation
    issue(2'b00, 1'b0, 16'd300, 16'd200, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_dz", div_zero, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done || busy) ndone++; end
    chk("post_rst_idle", ndone, 0);
    @(posedge clk); #1;

`ifdef MULDIV_SIGNED_EN
    run(2'b10, 1'b1, 16'hFFF9, 16'd2);
    run(2'b11, 1'b1, 16'hFFF9, 16'd2);
    run(2'b10, 1'b1, 16'h8000, 16'hFFFF);
    run(2'b11, 1'b1, 16'h8000, 16'hFFFF);
    run(2'b01, 1'b1, 16'hFFFF, 16'd1);
`endif

    // randomized ops, some back-to-back
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 9));
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      issue(rop, 1'($urandom_range(0, 1)), ra, rb, 1'b1);
      wait_done(nb);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit for the pipelined core's execute stage.
- Accepts one operation per start pulse, iterates one bit per cycle (shift-add multiply, restoring divide), and returns a registered result with a one-cycle done pulse.
- The exec stage stalls IF/ID/EX on busy and clears the unit with flush on branch or pipeline flush.

Parameters:
- WIDTH, 16, operand and result width in bits; legal values 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only when busy=0.
- flush  in  1  synchronous abort of the in-flight operation.
- op  in  2  operation: 00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 REM remainder.
- sgn  in  1  signed-operation request; meaningful only with MULDIV_SIGNED_EN.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  operation in flight; the pipeline stalls while high.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  selected result; held until the next accepted start.
- div_zero  out  1  set with done when DIV/REM had b=0; held with result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, div_zero=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures a, b, op and sgn into internal registers and moves to RUN with counter=0.
- RUN: performs one iteration per cycle and increments the counter. When counter reaches WIDTH-1 on an edge, moves to DONE and registers result.
- DONE: done=1 for exactly one cycle, then IDLE; a start in DONE is accepted (see below).
- Latency: start high in cycle 0, busy=1 in cycles 1..WIDTH, done=1 in cycle WIDTH+1. Result is valid from cycle WIDTH+1 until the edge that accepts the next start.
- busy=1 only in RUN; busy=0 in IDLE and DONE.
- Back-to-back: start in the DONE cycle is accepted, giving RUN in the next cycle. The done pulse still occurs and result is still valid during that DONE cycle.
- start while busy=1 is ignored. The operands are not recaptured and no error is flagged.
- MUL: full 2*WIDTH product is accumulated; op 00 returns bits [WIDTH-1:0], op 01 returns bits [2*WIDTH-1:WIDTH]. The product is computed without overflow.
- DIV/REM, unsigned, restoring: quotient and remainder satisfy a = q*b + r with 0 <= r < b.
- Divide by zero (op 1x, captured b=0):
  - Transition RUN->DONE after the first RUN cycle: busy in cycle 1, done in cycle 2.
  - Quotient = all ones; remainder = a; div_zero=1.
- div_zero=0 for every MUL and for every DIV/REM with b!=0. div_zero is updated only when done asserts.
- flush=1 on a clock edge, in any state:
  - Returns to IDLE and clears busy and done.
  - No done pulse is produced for the aborted operation.
  - result and div_zero keep their previous values.
- flush and start in the same cycle: flush wins and start is dropped.
- Reset asserted mid-operation aborts immediately to reset values. Operation resumes only on a new start after reset deassertion.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - sgn=1 selects two's-complement operation. Operands are converted to magnitudes, the unsigned core runs, and the result is negated in the DONE-cycle register load. Latency is unchanged.
  - MUL high half is the signed high half.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient = most-negative and remainder = 0, with div_zero=0.
  - Divide by zero gives quotient = all ones and remainder = a.
- Undefined: sgn is ignored (treated as 0) and all operations are unsigned. No sign-handling logic is synthesised.

Test Plan:
- WIDTH=16. a=300, b=200, op=00; then op=01 -> result 0xEA60, then 0x0000. busy high for exactly 16 cycles; done pulses in cycle 17 after the start cycle.
- a=0xFFFF, b=0xFFFF, op=01; then op=00 -> result 0xFFFE, then 0x0001. div_zero=0.
- a=1000, b=7, op=10; then op=11 -> 142, then 6. Issue a second start with a=9, b=3, op=10 during the done cycle -> accepted; next result 3 with done 17 cycles later.
- a=0x1234, b=0, op=10 -> done in cycle 2, result 0xFFFF, div_zero=1. Repeat with op=11 -> result 0x1234, div_zero=1.
- Start a=50, b=5, op=10; assert flush in cycle 5 -> busy=0 next cycle, no done pulse, result unchanged. Separately: start pulses in cycles 3..8 of a running op are ignored. Separately: reset low in cycle 9 -> all outputs 0 immediately.
- MULDIV_SIGNED_EN defined, sgn=1:
  - a=-7 (0xFFF9), b=2, op=10 -> 0xFFFD (-3); op=11 -> 0xFFFF (-1).
  - a=0x8000, b=0xFFFF, op=10 -> 0x8000, div_zero=0.
